pc_fetch_ctrl: RTL

Sequencer for the 32-bit program-counter register and the instruction-memory fetch port.
- Holds the PC and issues one instruction fetch at a time over a req/gnt/rvalid handshake.
- Buffers the returned instruction for decode behind a valid/ready handshake.
- Applies branch/jump redirects and trap vectoring, and discards stale responses.
- Sits between the PC register stage and the decode stage of the core.

---
 rtl/pc_fetch_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// PC register and single-outstanding instruction fetch sequencer.
// Buffers one fetched instruction for decode; applies redirect/trap flushes.
module pc_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap,
  output logic [XLEN-1:0] pc
);

  // state | meaning
  // REQ   | presenting pc to memory while the buffer can take a result
  // WAIT  | request granted, waiting for rvalid
  localparam logic STATE_REQ  = 1'b0;
  localparam logic STATE_WAIT = 1'b1;

  logic            state;
  logic            discard;
  logic            buf_free;
  logic            req_fire;
  logic            flush;
  logic            rsp;
  logic            capture;
  logic [XLEN-1:0] flush_pc;

  assign buf_free  = !if_valid || if_ready;
  assign imem_req  = !rst && (state == STATE_REQ) && buf_free;
  assign imem_addr = pc;
  assign req_fire  = imem_req && imem_gnt;
  assign flush     = trap || redirect;
  assign flush_pc  = trap ? TRAP_VEC : (redirect_pc & ~XLEN'(3));
  assign rsp       = (state == STATE_WAIT) && imem_rvalid;
  assign capture   = rsp && !discard && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= STATE_REQ;
      discard  <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      if (flush)        pc <= flush_pc;
      else if (capture) pc <= pc + XLEN'(4);

      if (flush)         if_valid <= 1'b0;
      else if (capture)  if_valid <= 1'b1;
      else if (if_ready) if_valid <= 1'b0;

      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
      end

      // A flush while a fetch is in flight marks its response as stale,
      // except when that response lands on the flush edge itself.
      case (state)
        STATE_REQ: begin
          if (req_fire) begin
            state   <= STATE_WAIT;
            discard <= flush;
          end
        end
        default: begin
          if (rsp) begin
            state   <= STATE_REQ;
            discard <= 1'b0;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
